// File: rtl/step_phase_decoder_pkg.sv
// Shared stepper phase encoding: pattern order {ap,bp,an,bn}, angle 0..7, CW raises the angle.
// Intended for reuse by the phase generator on the motor controller side.
package step_pkg;

  localparam int ANGLE_W = 3;
  localparam logic CW  = 1'b1;
  localparam logic CCW = 1'b0;

  // Element i is the coil pattern for electrical angle i.
  localparam logic [7:0][3:0] ANGLE_PAT = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  typedef struct packed {
    logic               legal;
    logic               idle;
    logic [ANGLE_W-1:0] angle;
  } ang_t;

  // Anything nonzero that is not in the table (opposite coils or 3+ lines) is illegal.
  function automatic ang_t decode_pattern(input logic [3:0] p);
    ang_t r;
    r.legal = 1'b0;
    r.idle  = (p == 4'b0000);
    r.angle = '0;
    for (int i = 0; i < 8; i++) begin
      if (p == ANGLE_PAT[i]) begin
        r.legal = 1'b1;
        r.angle = ANGLE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Coil-line inputs and decoded step/position outputs of the phase decoder.
interface step_phase_decoder_if #(parameter int POS_W = 16);
  logic             in_ap, in_bp, in_an, in_bn;
  logic             clr;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic [2:0]       angle;
  logic             valid;
  logic             half_step;
  logic             err_illegal;
  logic             err_skip;

  modport master (
    output in_ap, in_bp, in_an, in_bn, clr,
    input  step, dir, pos, angle, valid, half_step, err_illegal, err_skip
  );

  modport slave (
    input  in_ap, in_bp, in_an, in_bn, clr,
    output step, dir, pos, angle, valid, half_step, err_illegal, err_skip
  );
endinterface

// File: rtl/step_phase_decoder_phase_input_filter.sv
// 2-flop synchronizer plus stability counter; strobes once per newly stable pattern.
module phase_input_filter #(
  parameter int FILT = 4
) (
  input  logic       clk,
  input  logic       xres,
  input  logic [3:0] pins,
  output logic [3:0] pat,
  output logic       stb
);
  logic [3:0] s1, s2, prev, acc;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge xres) begin
    if (!xres) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      s1   <= pins;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev)           cnt <= '0;
      else if (cnt != 4'(FILT)) cnt <= cnt + 4'd1;
      if (stb) acc <= prev;
    end
  end

  // cnt hits FILT-1 exactly once per stable run; acc suppresses re-accepting the same pattern.
  assign stb = (cnt == 4'(FILT - 1)) && (prev != acc);
  assign pat = prev;

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes filtered coil patterns into step pulses, direction and a signed half-step position.
module step_phase_decoder #(
  parameter int FILT  = 4,
  parameter int POS_W = 16
) (
  input logic clk,
  input logic xres,
  step_phase_decoder_if.slave bus
);
  import step_pkg::*;

  logic [3:0]         pat;
  logic               stb;
  ang_t               dec;
  logic [ANGLE_W-1:0] delta, back;

  logic               step_q, dir_q, valid_q, half_q, eill_q, eskip_q;
  logic [POS_W-1:0]   pos_q;
  logic [ANGLE_W-1:0] angle_q;
  logic               step_n, dir_n, valid_n, half_n, eill_n, eskip_n;
  logic [POS_W-1:0]   pos_n;
  logic [ANGLE_W-1:0] angle_n;
  logic               new_ill, new_skip;

  phase_input_filter #(.FILT(FILT)) u_filt (
    .clk  (clk),
    .xres (xres),
    .pins ({bus.in_ap, bus.in_bp, bus.in_an, bus.in_bn}),
    .pat  (pat),
    .stb  (stb)
  );

  assign dec   = decode_pattern(pat);
  assign delta = dec.angle - angle_q;
  assign back  = 3'd0 - delta;

  always_comb begin
    step_n   = 1'b0;
    dir_n    = dir_q;
    pos_n    = pos_q;
    angle_n  = angle_q;
    valid_n  = valid_q;
    half_n   = half_q;
    new_ill  = 1'b0;
    new_skip = 1'b0;
    if (stb) begin
      if (dec.idle) begin
        valid_n = 1'b0;
      end else if (!dec.legal) begin
        new_ill = 1'b1;
        valid_n = 1'b0;
      end else if (!valid_q) begin
        angle_n = dec.angle;
        valid_n = 1'b1;
      end else begin
        angle_n = dec.angle;
        case (delta)
          3'd1, 3'd2: begin
            step_n = 1'b1;
            dir_n  = CW;
            half_n = (delta == 3'd1);
            pos_n  = pos_q + POS_W'(delta);
          end
          3'd6, 3'd7: begin
            step_n = 1'b1;
            dir_n  = CCW;
            half_n = (delta == 3'd7);
            pos_n  = pos_q - POS_W'(back);
          end
          default: new_skip = 1'b1;
        endcase
      end
    end
    // clr wins over the position update but not over an error raised in the same cycle.
    if (bus.clr) begin
      pos_n   = '0;
      eill_n  = new_ill;
      eskip_n = new_skip;
    end else begin
      eill_n  = eill_q  | new_ill;
      eskip_n = eskip_q | new_skip;
    end
  end

  always_ff @(posedge clk or negedge xres) begin
    if (!xres) begin
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      half_q  <= 1'b0;
      eill_q  <= 1'b0;
      eskip_q <= 1'b0;
    end else begin
      step_q  <= step_n;
      dir_q   <= dir_n;
      pos_q   <= pos_n;
      angle_q <= angle_n;
      valid_q <= valid_n;
      half_q  <= half_n;
      eill_q  <= eill_n;
      eskip_q <= eskip_n;
    end
  end

  assign bus.step        = step_q;
  assign bus.dir         = dir_q;
  assign bus.pos         = pos_q;
  assign bus.angle       = angle_q;
  assign bus.valid       = valid_q;
  assign bus.half_step   = half_q;
  assign bus.err_illegal = eill_q;
  assign bus.err_skip    = eskip_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed stimulus with queued expected output snapshots; a monitor pops one per visible output change.
module tb_step_phase_decoder;

  typedef struct packed {
    logic       step;
    logic       dir;
    logic [3:0] pos;
    logic [2:0] angle;
    logic       valid;
    logic       half;
    logic       eill;
    logic       eskip;
  } snap_t;

  logic clk  = 1'b0;
  logic xres = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  snap_t exp_q[$];
  string nm_q[$];

  step_phase_decoder_if #(.POS_W(4)) bus ();

  step_phase_decoder #(.FILT(4), .POS_W(4)) dut (
    .clk  (clk),
    .xres (xres),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t cur_snap();
    snap_t s;
    s.step  = bus.step;
    s.dir   = bus.dir;
    s.pos   = bus.pos;
    s.angle = bus.angle;
    s.valid = bus.valid;
    s.half  = bus.half_step;
    s.eill  = bus.err_illegal;
    s.eskip = bus.err_skip;
    return s;
  endfunction

  function automatic snap_t strip(input snap_t x);
    snap_t r;
    r = x;
    r.step = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (step,dir,pos[4],angle[3],valid,half,eill,eskip)", nm, act, want);
  endtask

  task automatic ev(input string nm, input logic st, input logic d, input int p, input int a,
                    input logic v, input logic h, input logic ei, input logic es);
    snap_t e;
    e.step = st; e.dir = d; e.pos = 4'(p); e.angle = 3'(a);
    e.valid = v; e.half = h; e.eill = ei; e.eskip = es;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic apply(input logic [3:0] p, input int hold);
    {bus.in_ap, bus.in_bp, bus.in_an, bus.in_bn} = p;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: any change in registered outputs, or a step pulse, is one DUT response.
  initial begin
    snap_t s, last, e;
    string nm;
    last = '0;
    forever begin
      @(negedge clk);
      s = cur_snap();
      if (!xres) begin
        last = strip(s);
      end else if (s.step || strip(s) != last) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got %h want none", s);
        end else begin
          e  = exp_q.pop_front();
          nm = nm_q.pop_front();
          chk(nm, 32'(s), 32'(e));
        end
        last = strip(s);
      end
    end
  end

  initial begin
    logic [3:0] wp [7];
    int         wa [7];
    wp = '{4'b0011, 4'b0001, 4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110};
    wa = '{5, 6, 7, 0, 1, 2, 3};

    {bus.in_ap, bus.in_bp, bus.in_an, bus.in_bn} = 4'b0000;
    bus.clr = 1'b0;
    #2 xres = 1'b0;
    @(negedge clk);
    chk("reset_vals", 32'(cur_snap()), 32'd0);
    @(posedge clk);
    #1 xres = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1-2-phase CW
    ev("cw_resync", 0, 0, 0, 0, 1, 0, 0, 0); apply(4'b1000, 10);
    ev("cw_s1",     1, 1, 1, 1, 1, 1, 0, 0); apply(4'b1100, 10);
    ev("cw_s2",     1, 1, 2, 2, 1, 1, 0, 0); apply(4'b0100, 10);
    ev("cw_s3",     1, 1, 3, 3, 1, 1, 0, 0); apply(4'b0110, 10);
    ev("idle",      0, 1, 3, 3, 0, 1, 0, 0); apply(4'b0000, 10);
    ev("clr1",      0, 1, 0, 3, 0, 1, 0, 0); pulse_clr();
    drain("drain_cw");

    // 2-phase CCW
    ev("ccw_resync", 0, 1,  0, 7, 1, 1, 0, 0); apply(4'b1001, 10);
    ev("ccw_s1",     1, 0, -2, 5, 1, 0, 0, 0); apply(4'b0011, 10);
    ev("ccw_s2",     1, 0, -4, 3, 1, 0, 0, 0); apply(4'b0110, 10);
    ev("ccw_s3",     1, 0, -6, 1, 1, 0, 0, 0); apply(4'b1100, 10);
    ev("ccw_s4",     1, 0, -8, 7, 1, 0, 0, 0); apply(4'b1001, 10);
    drain("drain_ccw");

    // Glitches: 3 cycles is filtered, 6 cycles is two real half steps
    ev("gl_hold", 1, 1, -6, 1, 1, 0, 0, 0); apply(4'b1100, 10);
    apply(4'b1000, 3);
    apply(4'b1100, 12);
    drain("drain_glitch3");
    ev("gl6_ccw", 1, 0, -7, 0, 1, 1, 0, 0);
    ev("gl6_cw",  1, 1, -6, 1, 1, 1, 0, 0);
    apply(4'b1000, 6);
    apply(4'b1100, 12);
    drain("drain_glitch6");

    // Illegal, resync, skip, clear
    ev("illegal",    0, 1, -6, 1, 0, 1, 1, 0); apply(4'b1010, 10);
    ev("ill_resync", 0, 1, -6, 0, 1, 1, 1, 0); apply(4'b1000, 10);
    ev("skip",       0, 1, -6, 4, 1, 1, 1, 1); apply(4'b0010, 10);
    ev("clr2",       0, 1,  0, 4, 1, 1, 0, 0); pulse_clr();
    drain("drain_err");

    // Climb to +7, wrap to -8, then clr colliding with an accepted step
    for (int i = 0; i < 7; i++) begin
      ev($sformatf("climb%0d", i), 1, 1, i + 1, wa[i], 1, 1, 0, 0);
      apply(wp[i], 10);
    end
    ev("wrap", 1, 1, -8, 4, 1, 1, 0, 0); apply(4'b0010, 10);
    ev("clr_step", 1, 1, 0, 5, 1, 1, 0, 0);
    {bus.in_ap, bus.in_bp, bus.in_an, bus.in_bn} = 4'b0011;
    repeat (6) @(posedge clk);
    #1 bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drain("drain_wrap");

    // Reset before the pending pattern is accepted
    apply(4'b0001, 3);
    xres = 1'b0;
    @(negedge clk);
    chk("reset_mid", 32'(cur_snap()), 32'd0);
    ev("rst_resync", 0, 0, 0, 6, 1, 0, 0, 0);
    @(posedge clk);
    #1 xres = 1'b1;
    apply(4'b0001, 12);
    ev("rst_s1", 1, 1, 1, 7, 1, 1, 0, 0); apply(4'b1001, 10);
    drain("drain_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
